stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Run-control sequencer for the stopwatch counter cascade. It synchronises and debounces three active-low push-buttons (start/stop, lap, clear) and runs a 4-state FSM. It produces one count-enable tick per 0.1 s for the digit counters, a synchronous clear pulse, and a display-freeze flag for lap hold. It sits between the board buttons and the 0.1 s / 1 s / 10 s / minute counter chain. It replaces the free-running per-digit dividers with a single gated tick.

Parameters:
TICK_DIV, 5000000, clocks per 0.1 s tick at 50 MHz (must be >= 2)
DEB_CYCLES, 1000000, consecutive stable clocks needed to accept a button level (20 ms; must be >= 1)

Ports:
i_clk  in  1  system clock (50 MHz)
i_reset_n  in  1  asynchronous active-low reset
i_key_start_n  in  1  raw start/stop button, 0 = pressed, asynchronous
i_key_lap_n  in  1  raw lap button, 0 = pressed, asynchronous
i_key_clear_n  in  1  raw clear button, 0 = pressed, asynchronous
i_at_max  in  1  counter chain is at its maximum value (used only with the optional feature)
o_tick  out  1  one-cycle count enable for the least-significant digit counter
o_clear  out  1  one-cycle synchronous clear for all digit counters
o_freeze  out  1  1 = display registers hold their value (lap)
o_running  out  1  1 in RUN or LAP
o_paused  out  1  1 in PAUSE
o_ovf  out  1  overflow halt flag (constant 0 without the optional feature)
o_state  out  2  IDLE=0, RUN=1, LAP=2, PAUSE=3

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0. Prescaler 0. Debounce counters 0. Debounced levels = released.
- Button front end, per key:
  - 2-FF synchroniser.
  - Debounce counter: resets when the synced level differs from the debounced level. When it reaches DEB_CYCLES, the debounced level takes the synced level and the counter resets.
  - Press event = debounced released→pressed transition, exactly 1 cycle wide. Release generates no event.
  - Latency from a raw press to the event pulse: 2 + DEB_CYCLES + 1 clocks.
- Event priority when events fall in the same cycle: clear > start > lap. Lower-priority events in that cycle are dropped.
- FSM, registered; the new state is visible the cycle after the event:
  - IDLE: start → RUN. Clear → IDLE with an o_clear pulse. Lap ignored.
  - RUN: start → PAUSE. Lap → LAP. Clear ignored.
  - LAP: lap → RUN (freeze released). Start → PAUSE (freeze released). Clear ignored.
  - PAUSE: start → RUN. Clear → IDLE with an o_clear pulse. Lap ignored.
- Outputs from the state register:
  - o_running = RUN|LAP.
  - o_freeze = LAP.
  - o_paused = PAUSE.
- Prescaler, width $clog2(TICK_DIV):
  - Increments every clock in RUN or LAP.
  - Holds its value in PAUSE, so the sub-tick fraction is preserved.
  - Forced to 0 in IDLE and on any cycle where o_clear is generated.
  - Wraps TICK_DIV-1 → 0.
- o_tick: registered, 1 for exactly one clock on the cycle after the prescaler reaches TICK_DIV-1 while in RUN/LAP. Counting continues during LAP. No tick in IDLE or PAUSE.
- o_clear: registered, 1 clock wide, the cycle after the accepted clear event. It is coincident with the transition to IDLE.
- Reset mid-operation: immediate return to the reset values; no o_clear pulse is generated.

Optional Feature:
STOPWATCH_CTRL_OVF_HALT_EN
- Defined:
  - If i_at_max=1 while an o_tick would be issued, that tick is suppressed and the FSM enters PAUSE. o_ovf is set to 1.
  - In this halt, start is ignored; only clear (→ IDLE, o_clear pulse) is accepted.
  - o_ovf clears together with o_clear.
- Not defined:
  - i_at_max is ignored and the counters wrap naturally.
  - o_ovf is tied to 0.

Test Plan:
- TICK_DIV=10, DEB_CYCLES=4; hold start low for 10 clocks → event 7 clocks after the press edge, o_state=1 next cycle, o_tick every 10 clocks.
- Start pulse low for 2 clocks only (bounce) → no event, o_state stays 0.
- RUN, press start after 3 prescaler counts → PAUSE, no ticks; start again → next o_tick after exactly 7 more clocks.
- RUN, press lap → o_freeze=1 and o_tick continues; press lap again → o_freeze=0, o_state=1.
- PAUSE, clear and start debounced in the same cycle → clear wins: o_clear=1 for 1 clock, o_state=0, prescaler 0.
- With STOPWATCH_CTRL_OVF_HALT_EN and i_at_max=1 in RUN → tick suppressed, o_ovf=1, o_state=3, start ignored; clear → o_ovf=0, o_clear pulse. Without the macro → ticks continue and o_ovf=0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run control: button sync/debounce, 4-state FSM, gated 0.1 s tick.
// Ports: i_clk, i_reset_n, i_key_{start,lap,clear}_n, i_at_max -> o_tick,
//   o_clear, o_freeze, o_running, o_paused, o_ovf, o_state.
// Optional macro STOPWATCH_CTRL_OVF_HALT_EN: halt into PAUSE at counter max.
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 5000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_key_start_n,
  input  logic       i_key_lap_n,
  input  logic       i_key_clear_n,
  input  logic       i_at_max,
  output logic       o_tick,
  output logic       o_clear,
  output logic       o_freeze,
  output logic       o_running,
  output logic       o_paused,
  output logic       o_ovf,
  output logic [1:0] o_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_LAP   = 2'd2;
  localparam logic [1:0] S_PAUSE = 2'd3;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DEB_CYCLES + 1);

  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  // key index: 0 = start, 1 = lap, 2 = clear
  logic [2:0] key_n;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] deb_q, deb_d;
  logic [2:0] dly_q;
  logic [2:0] ev_q;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];

  assign key_n = {i_key_clear_n, i_key_lap_n, i_key_start_n};

  // Counter runs only while the synced level disagrees with the
  // accepted level; the final matching count commits the new level.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      deb_d[k] = deb_q[k];
      cnt_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == DEB_LAST) begin
          deb_d[k] = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      dly_q   <= '1;
      ev_q    <= '0;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      dly_q   <= deb_q;
      // released(1) -> pressed(0) edge of the accepted level
      ev_q    <= dly_q & ~deb_q;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // One event per cycle: clear beats start beats lap.
  logic sel_clr, sel_start, sel_lap;

  always_comb begin
    sel_clr   = 1'b0;
    sel_start = 1'b0;
    sel_lap   = 1'b0;
    priority case (1'b1)
      ev_q[2]: sel_clr   = 1'b1;
      ev_q[0]: sel_start = 1'b1;
      ev_q[1]: sel_lap   = 1'b1;
      default: ;
    endcase
  end

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic          clr_q, clr_d;
  logic          ovf_q, ovf_d;
  logic          run_w, wrap_w;

  assign run_w  = (state_q == S_RUN) || (state_q == S_LAP);
  assign wrap_w = (pre_q == PRE_MAX);

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    tick_d  = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel_clr) begin
          clr_d = 1'b1;
        end else if (sel_start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (sel_start) begin
          state_d = S_PAUSE;
        end else if (sel_lap) begin
          state_d = S_LAP;
        end
      end
      S_LAP: begin
        if (sel_lap) begin
          state_d = S_RUN;
        end else if (sel_start) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (sel_clr) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
        end else if (sel_start && !ovf_q) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (run_w && wrap_w) begin
      tick_d = 1'b1;
`ifdef STOPWATCH_CTRL_OVF_HALT_EN
      // Overflow halt wins over any same-cycle start/lap.
      if (i_at_max) begin
        tick_d  = 1'b0;
        state_d = S_PAUSE;
        ovf_d   = 1'b1;
      end
`endif
    end

    if (clr_d) begin
      ovf_d = 1'b0;
    end
  end

  // PAUSE holds the fraction so a resume keeps sub-tick time.
  always_comb begin
    pre_d = pre_q;
    if ((state_q == S_IDLE) || clr_d) begin
      pre_d = '0;
    end else if (run_w) begin
      pre_d = wrap_w ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      ovf_q   <= ovf_d;
    end
  end

`ifndef STOPWATCH_CTRL_OVF_HALT_EN
  logic unused_at_max;
  assign unused_at_max = i_at_max;
`endif

  assign o_tick    = tick_q;
  assign o_clear   = clr_q;
  assign o_freeze  = (state_q == S_LAP);
  assign o_running = run_w;
  assign o_paused  = (state_q == S_PAUSE);
  assign o_ovf     = ovf_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed run/lap/pause/clear script, then
// random key traffic checked every cycle against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int TD  = 10;
  localparam int DEB = 4;
  localparam int NC  = 3000;
  localparam int NDIR = 180;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       k_start_n = 1'b1;
  logic       k_lap_n = 1'b1;
  logic       k_clear_n = 1'b1;
  logic       at_max = 1'b0;
  logic       o_tick, o_clear, o_freeze, o_running, o_paused, o_ovf;
  logic [1:0] o_state;

  int errors = 0;
  int checks = 0;

  stopwatch_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DEB)) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_key_start_n(k_start_n),
    .i_key_lap_n(k_lap_n),
    .i_key_clear_n(k_clear_n),
    .i_at_max(at_max),
    .o_tick(o_tick),
    .o_clear(o_clear),
    .o_freeze(o_freeze),
    .o_running(o_running),
    .o_paused(o_paused),
    .o_ovf(o_ovf),
    .o_state(o_state)
  );

  always #5 clk = ~clk;

  // Model history: raw key level applied in cycle n, accepted level in n.
  logic raw [3][NC];
  logic deb [3][NC+1];

  int   m_st;
  int   m_acc;
  logic m_tick, m_clr, m_ovf;

  function automatic logic rawv(int k, int n);
    return (n < 0) ? 1'b1 : raw[k][n];
  endfunction

  function automatic logic debv(int k, int n);
    return (n < 0) ? 1'b1 : deb[k][n];
  endfunction

  function automatic logic [7:0] dut_vec();
    return {o_state, o_tick, o_clear, o_freeze, o_running, o_paused, o_ovf};
  endfunction

  function automatic logic [7:0] mdl_vec();
    logic [1:0] s;
    s = 2'(m_st);
    return {s, m_tick, m_clr, m_st == 2, m_st == 1 || m_st == 2,
            m_st == 3, m_ovf};
  endfunction

  task automatic lit(string nm, int n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d want %0d", nm, n, act, exp);
    end
  endtask

  // A level is accepted once the synced key (raw delayed two clocks) has
  // shown the same new value for DEB straight cycles; a press event is
  // visible the cycle after the accepted level has dropped.
  task automatic model_step(int n);
    logic s, all, ev[3];
    int   nst, pre;
    logic nclr, ntick, novf, run;
    for (int k = 0; k < 3; k++) begin
      s   = rawv(k, n - 2);
      all = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        if (rawv(k, n - 2 - j) != s) all = 1'b0;
      end
      deb[k][n+1] = (all && s != deb[k][n]) ? s : deb[k][n];
      ev[k] = debv(k, n - 2) & ~debv(k, n - 1);
    end
    if (ev[2]) begin
      ev[0] = 1'b0;
      ev[1] = 1'b0;
    end
    if (ev[0]) ev[1] = 1'b0;

    pre   = m_acc % TD;
    run   = (m_st == 1) || (m_st == 2);
    nst   = m_st;
    nclr  = 1'b0;
    ntick = 1'b0;
    novf  = m_ovf;
    if (m_st == 0) begin
      if (ev[2]) nclr = 1'b1;
      else if (ev[0]) nst = 1;
    end else if (m_st == 1) begin
      if (ev[0]) nst = 3;
      else if (ev[1]) nst = 2;
    end else if (m_st == 2) begin
      if (ev[1]) nst = 1;
      else if (ev[0]) nst = 3;
    end else begin
      if (ev[2]) begin
        nst  = 0;
        nclr = 1'b1;
      end else if (ev[0] && !m_ovf) nst = 1;
    end
    if (run && pre == TD - 1) begin
      ntick = 1'b1;
`ifdef STOPWATCH_CTRL_OVF_HALT_EN
      if (at_max) begin
        ntick = 1'b0;
        nst   = 3;
        novf  = 1'b1;
      end
`endif
    end
    if (nclr) novf = 1'b0;
    if (m_st == 0 || nclr) m_acc = 0;
    else if (run) m_acc = m_acc + 1;
    m_st   = nst;
    m_clr  = nclr;
    m_tick = ntick;
    m_ovf  = novf;
  endtask

  function automatic logic in_rng(int n, int a, int b);
    return (n >= a) && (n < b);
  endfunction

  int   hold [3];
  logic lvl [3];

  task automatic drive(int n);
    logic st, lp, cl;
    if (n < NDIR) begin
      st = !(in_rng(n, 0, 2) || in_rng(n, 10, 20) || in_rng(n, 73, 81) ||
             in_rng(n, 90, 98) || in_rng(n, 110, 118) ||
             in_rng(n, 130, 138) || in_rng(n, 150, 158));
      lp = !(in_rng(n, 40, 48) || in_rng(n, 60, 68));
      cl = !in_rng(n, 130, 138);
      raw[0][n] = st;
      raw[1][n] = lp;
      raw[2][n] = cl;
      at_max = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (hold[k] == 0) begin
          lvl[k]  = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
          hold[k] = $urandom_range(1, 12);
        end
        hold[k]--;
        raw[k][n] = lvl[k];
      end
      // bias against clear so runs last long enough to tick
      if ($urandom_range(0, 3) != 0) raw[2][n] = 1'b1;
      at_max = ($urandom_range(0, 5) == 0);
    end
    k_start_n = raw[0][n];
    k_lap_n   = raw[1][n];
    k_clear_n = raw[2][n];
  endtask

  task automatic pins(int n);
    if (n == 1)   lit("reset_state", n, o_state, 0);
    if (n == 9)   lit("bounce_idle", n, o_state, 0);
    if (n == 17)  lit("pre_start_idle", n, o_state, 0);
    if (n == 18)  lit("start_run", n, o_state, 1);
    if (n == 27)  lit("tick_early", n, o_tick, 0);
    if (n == 28)  lit("tick_first", n, o_tick, 1);
    if (n == 38)  lit("tick_second", n, o_tick, 1);
    if (n == 48)  lit("lap_freeze", n, o_freeze, 1);
    if (n == 58)  lit("lap_tick", n, o_tick, 1);
    if (n == 68)  lit("unlap_freeze", n, o_freeze, 0);
    if (n == 68)  lit("unlap_state", n, o_state, 1);
    if (n == 81)  lit("pause_state", n, o_state, 3);
    if (n == 88)  lit("pause_no_tick", n, o_tick, 0);
    if (n == 98)  lit("resume_state", n, o_state, 1);
    if (n == 104) lit("resume_tick_early", n, o_tick, 0);
    if (n == 105) lit("resume_tick", n, o_tick, 1);
    if (n == 138) lit("clr_wins_clear", n, o_clear, 1);
    if (n == 138) lit("clr_wins_state", n, o_state, 0);
    if (n == 139) lit("clr_width", n, o_clear, 0);
    if (n == 158) lit("restart_run", n, o_state, 1);
    if (n == 167) lit("restart_tick_early", n, o_tick, 0);
    if (n == 168) lit("restart_tick", n, o_tick, 1);
  endtask

  initial begin
    m_st   = 0;
    m_acc  = 0;
    m_tick = 1'b0;
    m_clr  = 1'b0;
    m_ovf  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      deb[k][0] = 1'b1;
      hold[k]   = 0;
      lvl[k]    = 1'b1;
    end
    repeat (3) @(negedge clk);
    lit("reset_outputs", -1, int'(dut_vec()), 0);
    rst_n = 1'b1;
    for (int n = 0; n < NC; n++) begin
      if (n > 0) @(negedge clk);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL model cycle %0d: dut %b model %b", n,
                 dut_vec(), mdl_vec());
      end
      pins(n);
      drive(n);
      model_step(n);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    lit("midrun_reset", NC, int'(dut_vec()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
